// File: rtl/ps2_pkg.sv
// ps2_pkg: state encodings, command and response bytes shared by the PS/2 mouse responder.
package ps2_pkg;
  typedef enum logic [5:0] {
    ST_POWERUP  = 6'b000001,
    ST_SEND_BAT = 6'b000010,
    ST_SEND_ID  = 6'b000100,
    ST_READY    = 6'b001000,
    ST_SEND_ACK = 6'b010000,
    ST_SEND_PKT = 6'b100000
  } state_t;
  localparam logic [7:0] CMD_RESET      = 8'hFF;
  localparam logic [7:0] CMD_EN_STREAM  = 8'hF4;
  localparam logic [7:0] CMD_DIS_STREAM = 8'hF5;
  localparam logic [7:0] RSP_ACK        = 8'hFA;
  localparam logic [7:0] RSP_RESEND     = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK     = 8'hAA;
  function automatic logic [7:0] rsp_of(input logic [7:0] c);
    return (c == CMD_RESET || c == CMD_EN_STREAM || c == CMD_DIS_STREAM) ? RSP_ACK : RSP_RESEND;
  endfunction
endpackage

// File: rtl/ps2_pwrup_timer.sv
// ps2_pwrup_timer: power-up delay counter; expire is high while running with the count at zero.
module ps2_pwrup_timer #(
  parameter int unsigned CYCLES = 25_000_000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign expire = run && cnt_q == '0;
  assign cnt_d = load ? W'(CYCLES - 1) : (run && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk_sys) begin
    if (!rst_n) cnt_q <= W'(CYCLES - 1);
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ps2_mouse_responder.sv
// ps2_mouse_responder: device-side PS/2 mouse emulator; acks host commands and streams 3-byte packets.
// Define PS2_RESP_BAT_EN to send the AA/DEV_ID self-test after power-up and after an FF reset command.
module ps2_mouse_responder
  import ps2_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 25_000_000,
  parameter logic [7:0]  DEV_ID         = 8'h00
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cmd_vld,
  input  logic [7:0]  cmd_data,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        mv_vld,
  input  logic [23:0] mv_data,
  output logic        mv_rdy,
  output logic        stream_en,
  output logic [5:0]  state
);
`ifdef PS2_RESP_BAT_EN
  localparam bit BAT_EN = 1'b1;
`else
  localparam bit BAT_EN = 1'b0;
`endif
  state_t      state_q, state_d;
  logic        go_q, go_d, busy_q, busy_d, tx_en_q, tx_en_d;
  logic        stream_en_q, stream_en_d, pend_vld_q, pend_vld_d;
  logic [7:0]  tx_data_q, tx_data_d, cmd_q, cmd_d, pend_q, pend_d, pc;
  logic [23:0] pkt_q, pkt_d;
  logic [1:0]  idx_q, idx_d;
  logic        expire, sending, done, pv, accept, fire;
  ps2_pwrup_timer #(.CYCLES(POWERUP_CYCLES)) u_timer (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .load   (state_q != ST_POWERUP),
    .run    (state_q == ST_POWERUP),
    .expire (expire)
  );
  assign sending   = !(state_q inside {ST_POWERUP, ST_READY});
  assign done      = tx_done && busy_q;
  // A command arriving with tx_done is treated as already pending for that tx_done.
  assign pv        = pend_vld_q || (cmd_vld && sending);
  assign pc        = (cmd_vld && sending) ? cmd_data : pend_q;
  assign mv_rdy    = state_q == ST_READY && stream_en_q && !cmd_vld && !pend_vld_q;
  assign accept    = mv_vld && mv_rdy;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign stream_en = stream_en_q;
  assign state     = state_q;
  always_comb begin
    state_d     = state_q;
    go_d        = 1'b0;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    pkt_d       = pkt_q;
    stream_en_d = stream_en_q;
    pend_vld_d  = pv;
    pend_d      = pc;
    fire        = go_q;
    case (state_q)
      ST_POWERUP: if (expire) begin
        state_d = BAT_EN ? ST_SEND_BAT : ST_READY;
        go_d    = BAT_EN;
      end
      ST_READY: if (cmd_vld || pend_vld_q) begin
        state_d    = ST_SEND_ACK;
        go_d       = 1'b1;
        cmd_d      = cmd_vld ? cmd_data : pend_q;
        pend_vld_d = 1'b0;
      end else if (accept) begin
        state_d = ST_SEND_PKT;
        go_d    = 1'b1;
        idx_d   = 2'd0;
        pkt_d   = mv_data;
      end
      default: if (done) begin
        if (state_q == ST_SEND_ACK)
          stream_en_d = cmd_q == CMD_EN_STREAM ? 1'b1 :
                        (cmd_q == CMD_RESET || cmd_q == CMD_DIS_STREAM) ? 1'b0 : stream_en_q;
        fire = 1'b1;
        if (pv) begin
          state_d    = ST_SEND_ACK;
          cmd_d      = pc;
          pend_vld_d = 1'b0;
        end else if (BAT_EN && state_q == ST_SEND_ACK && cmd_q == CMD_RESET) state_d = ST_SEND_BAT;
        else if (state_q == ST_SEND_BAT) state_d = ST_SEND_ID;
        else if (state_q == ST_SEND_PKT && idx_q != 2'd2) idx_d = idx_q + 2'd1;
        else begin
          state_d = ST_READY;
          fire    = 1'b0;
        end
      end
    endcase
    tx_en_d   = fire;
    tx_data_d = !fire ? tx_data_q :
                state_d == ST_SEND_BAT ? RSP_BAT_OK :
                state_d == ST_SEND_ID  ? DEV_ID :
                state_d == ST_SEND_ACK ? rsp_of(cmd_d) : pkt_d[{idx_d, 3'b000} +: 8];
    busy_d    = fire || (busy_q && !done);
  end
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q     <= ST_POWERUP;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      stream_en_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      cmd_q       <= '0;
      pkt_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      busy_q      <= busy_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      stream_en_q <= stream_en_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      cmd_q       <= cmd_d;
      pkt_q       <= pkt_d;
      idx_q       <= idx_d;
    end
  end
endmodule

// File: tb/tb_ps2_mouse_responder.sv
// tb_ps2_mouse_responder: scoreboard bench; emulates the byte transmitter and checks every transmitted byte.
module tb_ps2_mouse_responder;
`ifdef PS2_RESP_BAT_EN
  localparam bit BAT = 1'b1;
`else
  localparam bit BAT = 1'b0;
`endif
  logic        clk_sys = 1'b0, rst_n = 1'b0, cmd_vld = 1'b0, tx_done = 1'b0, mv_vld = 1'b0;
  logic [7:0]  cmd_data = '0;
  logic [23:0] mv_data = '0;
  logic        tx_en, mv_rdy, stream_en;
  logic [7:0]  tx_data, mon_e;
  logic [5:0]  state;
  logic        rdy_seen;
  int          tests = 0, fails = 0, cnt = 0;
  logic [7:0]  exp_q[$];
  always #5 clk_sys = ~clk_sys;
  ps2_mouse_responder #(.POWERUP_CYCLES(100), .DEV_ID(8'h00)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_data(cmd_data),
    .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done), .mv_vld(mv_vld),
    .mv_data(mv_data), .mv_rdy(mv_rdy), .stream_en(stream_en), .state(state)
  );
  // Transmitter model: tx_done three cycles after each tx_en.
  initial forever begin
    @(negedge clk_sys);
    if (tx_done) tx_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) tx_done = 1'b1;
    end else if (tx_en === 1'b1) cnt = 3;
  end
  // Monitor: every tx_en pops one expected byte.
  initial forever begin
    @(negedge clk_sys);
    if (tx_en === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_byte: got %02h, no byte expected", tx_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (tx_data !== mon_e) begin
          fails++;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_data, mon_e);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(negedge clk_sys);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (!(exp_q.size() == 0 && cnt == 0 && !tx_done && tx_en !== 1'b1 && state == 6'b001000) && n < lim) begin
      tick;
      n++;
    end
    tests++;
    if (n >= lim) begin
      fails++;
      $display("FAIL %s: timeout, state=%b expected bytes left=%0d", name, state, exp_q.size());
    end
  endtask
  task automatic wait_inflight(input string name);
    int n = 0;
    while (cnt == 0 && n < 50) begin
      tick;
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL %s: no byte in flight", name);
    end
  endtask
  task automatic send_cmd(input logic [7:0] c);
    tick;
    cmd_vld = 1'b1;
    cmd_data = c;
    tick;
    cmd_vld = 1'b0;
  endtask
  task automatic offer(input logic [23:0] d);
    tick;
    mv_data = d;
    mv_vld = 1'b1;
    tick;
    mv_vld = 1'b0;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h01);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    chk({tag, "_mv_rdy"}, 32'(mv_rdy), 32'h0);
    chk({tag, "_stream_en"}, 32'(stream_en), 32'h0);
  endtask
  initial begin
    repeat (3) tick;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    if (BAT) begin exp_q.push_back(8'hAA); exp_q.push_back(8'h00); end
    wait_idle("powerup", 400);
    chk("pwr_stream_en", 32'(stream_en), 32'h0);
    exp_q.push_back(8'hFA);
    if (BAT) begin exp_q.push_back(8'hAA); exp_q.push_back(8'h00); end
    send_cmd(8'hFF);
    wait_idle("cmd_ff", 200);
    chk("ff_stream_en", 32'(stream_en), 32'h0);
    exp_q.push_back(8'hFA);
    send_cmd(8'hF4);
    wait_idle("cmd_f4", 200);
    chk("f4_stream_en", 32'(stream_en), 32'h1);
    chk("f4_mv_rdy", 32'(mv_rdy), 32'h1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    offer(24'h030201);
    rdy_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && cnt == 0 && !tx_done && tx_en !== 1'b1 && state == 6'b001000) break;
      rdy_seen |= mv_rdy;
      tick;
    end
    chk("pkt_mv_rdy_low", 32'(rdy_seen), 32'h0);
    wait_idle("pkt", 200);
    chk("pkt_mv_rdy_after", 32'(mv_rdy), 32'h1);
    exp_q.push_back(8'h0A); exp_q.push_back(8'hFA);
    offer(24'h0C0B0A);
    wait_inflight("f5_byte0");
    send_cmd(8'hF5);
    wait_idle("f5_mid_pkt", 200);
    chk("f5_stream_en", 32'(stream_en), 32'h0);
    exp_q.push_back(8'hFA);
    send_cmd(8'hF4);
    wait_idle("cmd_f4_again", 200);
    exp_q.push_back(8'h1A); exp_q.push_back(8'hFE);
    offer(24'h3C2B1A);
    for (int i = 0; i < 50 && !tx_done; i++) tick;
    chk("e8_sync_tx_done", 32'(tx_done), 32'h1);
    cmd_vld = 1'b1;
    cmd_data = 8'hE8;
    tick;
    cmd_vld = 1'b0;
    wait_idle("e8_on_done", 200);
    chk("e8_stream_en", 32'(stream_en), 32'h1);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h04); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    tick;
    cmd_vld = 1'b1;
    cmd_data = 8'hE8;
    mv_vld = 1'b1;
    mv_data = 24'h060504;
    #1;
    chk("both_mv_rdy", 32'(mv_rdy), 32'h0);
    tick;
    cmd_vld = 1'b0;
    chk("both_state_ack", 32'(state), 32'h10);
    for (int i = 0; i < 100; i++) begin
      tick;
      if (mv_rdy) begin
        tick;
        break;
      end
    end
    mv_vld = 1'b0;
    wait_idle("both", 200);
    chk("both_stream_en", 32'(stream_en), 32'h1);
    exp_q.push_back(8'h07);
    offer(24'h090807);
    wait_inflight("rst_byte0");
    chk("rst_pre_state", 32'(state), 32'h20);
    rst_n = 1'b0;
    tick;
    chk_reset_vals("midrst");
    tick;
    rst_n = 1'b1;
    if (BAT) begin exp_q.push_back(8'hAA); exp_q.push_back(8'h00); end
    wait_idle("repowerup", 400);
    chk("repwr_stream_en", 32'(stream_en), 32'h0);
    repeat (10) tick;
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
